// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: per-cycle operation
// encoding and the priority resolver used by the sequencer and decode checks.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_CALL,
    PC_RET,
    PC_IRQ
  } pc_op_t;

  // Priority: stall > irq > ret > call > branch > increment (reset handled by the flops).
  function automatic pc_op_t resolve_op(
    input logic stall,
    input logic irq,
    input logic ret,
    input logic call,
    input logic branch
  );
    if (stall)       return PC_HOLD;
    else if (irq)    return PC_IRQ;
    else if (ret)    return PC_RET;
    else if (call)   return PC_CALL;
    else if (branch) return PC_BRANCH;
    else             return PC_INC;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: push/pop with full/empty flags; only the count is reset,
// entry contents are don't-care until written.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [0:(1 << IW) - 1];
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty & ~do_push;
  assign top_data = mem[IW'(count - CW'(1))];

  always_ff @(posedge clk) begin
    if (rst)          count <= '0;
    else if (do_push) count <= count + CW'(1);
    else if (do_pop)  count <= count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[IW'(count)] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: priority resolve, next-PC mux, PC register, return stack,
// sticky fault. Optional interrupt entry is built when PC_IRQ_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 8,
  parameter int unsigned         STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_IRQ_EN
  ,
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(8'hF0)
`endif
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Stall,
  input  logic                i_Branch,
  input  logic                i_Call,
  input  logic                i_Ret,
  input  logic [PC_WIDTH-1:0] i_Target,
  output logic [PC_WIDTH-1:0] o_PC,
  output logic [PC_WIDTH-1:0] o_PC_Plus1,
  output logic                o_Stack_Empty,
  output logic                o_Stack_Full,
  output logic                o_Fault
`ifdef PC_IRQ_EN
  ,
  input  logic                i_Irq,
  output logic                o_Irq_Ack
`endif
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  pc_op_t              op;
  logic                irq_req;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;
  logic [PC_WIDTH-1:0] push_data;
  logic [CW-1:0]       stack_count;
  logic                push;
  logic                pop;
  logic                fault_set;

`ifdef PC_IRQ_EN
  logic in_service;
  assign irq_req = i_Irq & ~in_service;
`else
  assign irq_req = 1'b0;
`endif

  assign op = resolve_op(i_Stall, irq_req, i_Ret, i_Call, i_Branch);

  assign o_PC_Plus1 = o_PC + PC_WIDTH'(1);

  // An interrupt pushes the current PC so the interrupted instruction re-executes.
  assign push      = (op == PC_CALL) || (op == PC_IRQ);
  assign pop       = (op == PC_RET);
  assign push_data = (op == PC_IRQ) ? o_PC : o_PC_Plus1;
  assign fault_set = (push && o_Stack_Full) || (pop && o_Stack_Empty);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ret_stack (
    .clk       (i_Clk),
    .rst       (i_Reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top_data  (stack_top),
    .count     (stack_count),
    .full      (o_Stack_Full),
    .empty     (o_Stack_Empty)
  );

  always_comb begin
    pc_next = o_PC;
    unique case (op)
      PC_HOLD:   pc_next = o_PC;
      PC_INC:    pc_next = o_PC_Plus1;
      PC_BRANCH: pc_next = i_Target;
      PC_CALL:   pc_next = i_Target;
      PC_RET:    pc_next = o_Stack_Empty ? o_PC_Plus1 : stack_top;
`ifdef PC_IRQ_EN
      PC_IRQ:    pc_next = IRQ_VECTOR;
`endif
      default:   pc_next = o_PC;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) o_PC <= RESET_VECTOR;
    else         o_PC <= pc_next;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset)        o_Fault <= 1'b0;
    else if (fault_set) o_Fault <= 1'b1;
  end

`ifdef PC_IRQ_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      in_service <= 1'b0;
      o_Irq_Ack  <= 1'b0;
    end else begin
      o_Irq_Ack <= (op == PC_IRQ);
      if (op == PC_IRQ)      in_service <= 1'b1;
      else if (op == PC_RET) in_service <= 1'b0;
    end
  end
`endif

  stack_count_bound: assert property (@(posedge i_Clk) stack_count <= CW'(STACK_DEPTH));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PCs and flags;
// the interrupt section is compiled when PC_IRQ_EN is defined.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, branch, call, ret;
  logic [7:0] target;
  logic [7:0] pc, pc_plus1;
  logic       empty, full, fault;
`ifdef PC_IRQ_EN
  logic       irq, irq_ack;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  pc_sequencer #(
    .PC_WIDTH     (8),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (8'h00)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Stall       (stall),
    .i_Branch      (branch),
    .i_Call        (call),
    .i_Ret         (ret),
    .i_Target      (target),
    .o_PC          (pc),
    .o_PC_Plus1    (pc_plus1),
    .o_Stack_Empty (empty),
    .o_Stack_Full  (full),
    .o_Fault       (fault)
`ifdef PC_IRQ_EN
    ,
    .i_Irq         (irq),
    .o_Irq_Ack     (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    rst = 1'b0; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00;
`ifdef PC_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_ctl();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_branch(input logic [7:0] t);
    branch = 1'b1; target = t;
    tick();
    clear_ctl();
  endtask

  logic [7:0] call_tgt [5];
  logic [7:0] ret_exp  [4];

  initial begin
    call_tgt = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
    ret_exp  = '{8'hC1, 8'hB1, 8'hA1, 8'h12};

    do_reset();
    check_vec("reset_pc", pc, 8'h00);
    check_vec("reset_empty", 8'(empty), 8'h01);
    check_vec("reset_full", 8'(full), 8'h00);
    check_vec("reset_fault", 8'(fault), 8'h00);
    check_vec("reset_plus1", pc_plus1, 8'h01);

    for (int i = 1; i <= 5; i++) begin
      tick();
      check_vec("idle_inc", pc, 8'(i));
    end

    // Reset overrides a simultaneous branch
    rst = 1'b1; branch = 1'b1; target = 8'h55;
    tick();
    clear_ctl();
    check_vec("mid_reset_pc", pc, 8'h00);

    do_branch(8'hFF);
    check_vec("branch_ff", pc, 8'hFF);
    check_vec("plus1_wrap", pc_plus1, 8'h00);
    tick();
    check_vec("inc_wrap", pc, 8'h00);
    check_vec("wrap_fault", 8'(fault), 8'h00);

    do_branch(8'h10);
    call = 1'b1; target = 8'h40;
    tick();
    clear_ctl();
    check_vec("call_pc", pc, 8'h40);
    check_vec("call_empty", 8'(empty), 8'h00);
    ret = 1'b1;
    tick();
    clear_ctl();
    check_vec("ret_pc", pc, 8'h11);
    check_vec("ret_empty", 8'(empty), 8'h01);

    // Nested calls from PC 11: pushes 12, A1, B1, C1; fifth push dropped
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; target = call_tgt[i];
      tick();
      clear_ctl();
      check_vec("nest_call_pc", pc, call_tgt[i]);
      check_vec("nest_full", 8'(full), (i >= 3) ? 8'h01 : 8'h00);
      check_vec("nest_fault", 8'(fault), (i == 4) ? 8'h01 : 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1'b1;
      tick();
      clear_ctl();
      check_vec("unwind_pc", pc, ret_exp[i]);
    end
    check_vec("unwind_empty", 8'(empty), 8'h01);
    check_vec("unwind_fault_sticky", 8'(fault), 8'h01);

    do_reset();
    check_vec("fault_clear", 8'(fault), 8'h00);
    do_branch(8'h20);
    ret = 1'b1;
    tick();
    clear_ctl();
    check_vec("ret_empty_pc", pc, 8'h21);
    check_vec("ret_empty_fault", 8'(fault), 8'h01);
    tick();
    check_vec("fault_hold_pc", pc, 8'h22);
    check_vec("fault_hold", 8'(fault), 8'h01);

    stall = 1'b1; branch = 1'b1; target = 8'h77;
    tick();
    clear_ctl();
    check_vec("stall_branch_pc", pc, 8'h22);
    stall = 1'b1; call = 1'b1; target = 8'h77;
    tick();
    clear_ctl();
    check_vec("stall_call_pc", pc, 8'h22);
    check_vec("stall_call_empty", 8'(empty), 8'h01);

    call = 1'b1; target = 8'h60;
    tick();
    clear_ctl();
    check_vec("call60_pc", pc, 8'h60);
    call = 1'b1; ret = 1'b1; target = 8'h99;
    tick();
    clear_ctl();
    check_vec("call_ret_pc", pc, 8'h23);
    check_vec("call_ret_empty", 8'(empty), 8'h01);
    branch = 1'b1; ret = 1'b1; target = 8'h99;
    tick();
    clear_ctl();
    check_vec("branch_ret_pc", pc, 8'h24);

`ifdef PC_IRQ_EN
    do_reset();
    do_branch(8'h33);
    irq = 1'b1;
    tick();
    check_vec("irq_pc", pc, 8'hF0);
    check_vec("irq_ack", 8'(irq_ack), 8'h01);
    tick();
    irq = 1'b0;
    check_vec("irq_masked_pc", pc, 8'hF1);
    check_vec("irq_ack_pulse", 8'(irq_ack), 8'h00);
    ret = 1'b1;
    tick();
    clear_ctl();
    check_vec("irq_ret_pc", pc, 8'h33);
    check_vec("irq_ret_empty", 8'(empty), 8'h01);
    check_vec("irq_fault", 8'(fault), 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
